// File: rtl/l2_array_sched.sv
// l2_array_sched: round-robin scheduler sharing one single-ported L2 flip-flop array
// between NUM_REQ requesters. One read or write is granted per cycle. The response
// (read data or write ack) is returned the cycle after the grant. The block also
// disarms the array write path after reset and runs a whole-array zeroing flush.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/we        per-requester request and op (1 = write)
//   req_addr/wdata      per-requester set index and write data (flattened)
//   req_ready           one-hot grant
//   resp_valid          one-cycle response pulse, cycle after grant
//   resp_rdata          read data for a read response, 0 otherwise
//   flush_req           pulse: zero every set
//   flush_done          one-cycle pulse after the last flush write
//   arr_csb/web/addr/din/dout  array port (csb/web active-low)
module l2_array_sched #(
   parameter int unsigned S_INDEX = 4,
   parameter int unsigned WIDTH   = 1,
   parameter int unsigned NUM_REQ = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_we,
   input  logic [NUM_REQ*S_INDEX-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [NUM_REQ-1:0]         resp_valid,
   output logic [WIDTH-1:0]           resp_rdata,
   input  logic                       flush_req,
   output logic                       flush_done,
   output logic                       arr_csb,
   output logic                       arr_web,
   output logic [S_INDEX-1:0]         arr_addr,
   output logic [WIDTH-1:0]           arr_din,
   input  logic [WIDTH-1:0]           arr_dout
);

   localparam int unsigned NUM_SETS = 2 ** S_INDEX;
   localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {StInit, StIdle, StBusy, StFlush, StFdone} state_e;

   state_e             state_q, state_d;
   logic [IdW-1:0]     prio_q, prio_d;
   logic [IdW-1:0]     pend_id_q, pend_id_d;
   logic               pend_we_q, pend_we_d;
   logic [S_INDEX-1:0] cnt_q, cnt_d;

   // Round-robin arbiter: rotate the valid vector so prio_q lands at bit 0, take the
   // first set bit, then rotate the offset back into a requester id.
   logic [2*NUM_REQ-1:0] rot_valid;
   logic                 gnt_found;
   logic [IdW-1:0]       gnt_off;
   logic [IdW:0]         gnt_sum;
   logic [IdW-1:0]       gnt_id;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic                 sel_we;
   logic [S_INDEX-1:0]   sel_addr;
   logic [WIDTH-1:0]     sel_din;
   logic                 grant_ok;

   always_comb begin
      rot_valid = {req_valid, req_valid} >> prio_q;
      gnt_found = 1'b0;
      gnt_off   = '0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            gnt_found = 1'b1;
            gnt_off   = IdW'(k);
         end
      end
      gnt_sum = {1'b0, prio_q} + {1'b0, gnt_off};
      gnt_id  = (gnt_sum >= (IdW + 1)'(NUM_REQ)) ? IdW'(gnt_sum - (IdW + 1)'(NUM_REQ))
                                                 : IdW'(gnt_sum);
      gnt_oh   = gnt_found ? (NUM_REQ'(1) << gnt_id) : '0;
      sel_we   = req_we[gnt_id];
      sel_addr = req_addr[32'(gnt_id) * S_INDEX +: S_INDEX];
      sel_din  = req_wdata[32'(gnt_id) * WIDTH +: WIDTH];
      // flush_req is only honoured from IDLE/BUSY; FDONE grants regardless.
      grant_ok = (state_q == StFdone) ||
                 (((state_q == StIdle) || (state_q == StBusy)) && !flush_req);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StInit;
         prio_q    <= '0;
         pend_id_q <= '0;
         pend_we_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         prio_q    <= prio_d;
         pend_id_q <= pend_id_d;
         pend_we_q <= pend_we_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      pend_id_d = pend_id_q;
      pend_we_d = pend_we_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         StInit: state_d = StIdle;
         StIdle, StBusy, StFdone: begin
            if (!grant_ok) begin
               state_d = StFlush;
               cnt_d   = '0;
            end else if (gnt_found) begin
               state_d   = StBusy;
               pend_id_d = gnt_id;
               pend_we_d = sel_we;
               prio_d    = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + IdW'(1);
            end else begin
               state_d = StIdle;
            end
         end
         StFlush: begin
            // Leave by state exit rather than letting the counter overflow.
            if (cnt_q == S_INDEX'(NUM_SETS - 1)) begin
               state_d = StFdone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + S_INDEX'(1);
            end
         end
         default: state_d = StInit;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      resp_rdata = '0;
      flush_done = 1'b0;
      arr_csb    = 1'b1;
      arr_web    = 1'b1;
      arr_addr   = '0;
      arr_din    = '0;
      unique case (state_q)
         // INIT is also the in-reset state; keep the array deselected until release.
         StInit: arr_csb = ~rst_n;
         StIdle, StBusy, StFdone: begin
            if (state_q == StBusy) begin
               for (int i = 0; i < int'(NUM_REQ); i++) begin
                  resp_valid[i] = (pend_id_q == IdW'(i));
               end
               resp_rdata = pend_we_q ? '0 : arr_dout;
            end
            flush_done = (state_q == StFdone);
            if (grant_ok && gnt_found) begin
               req_ready = gnt_oh;
               arr_csb   = 1'b0;
               arr_web   = ~sel_we;
               arr_addr  = sel_addr;
               arr_din   = sel_din;
            end
         end
         StFlush: begin
            arr_csb  = 1'b0;
            arr_web  = 1'b0;
            arr_addr = cnt_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_l2_array_sched.sv
module tb_l2_array_sched;

   localparam int unsigned S_INDEX  = 4;
   localparam int unsigned WIDTH    = 1;
   localparam int unsigned NUM_REQ  = 2;
   localparam int unsigned NUM_SETS = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid, req_we, req_wdata, req_ready, resp_valid;
   logic [7:0] req_addr;
   logic       resp_rdata, flush_req, flush_done;
   logic       arr_csb, arr_web, arr_din, arr_dout;
   logic [3:0] arr_addr;

   int errors = 0;
   int checks = 0;
   int fdone_seen;

   logic [3:0] widx [4] = '{4'd0, 4'd1, 4'd2, 4'd15};

   always #5 clk = ~clk;

   // Array model: captures the port when csb=0, a captured write commits on every
   // edge until a read is captured, dout shows the registered index.
   logic       mem [NUM_SETS] = '{default: 1'b0};
   logic       web_r  = 1'b1;
   logic [3:0] addr_r = 4'd0;
   logic       din_r  = 1'b0;

   always @(posedge clk) begin
      if (!web_r) mem[addr_r] <= din_r;
      if (!arr_csb) begin
         web_r  <= arr_web;
         addr_r <= arr_addr;
         din_r  <= arr_din;
      end
   end
   assign arr_dout = mem[addr_r];

   l2_array_sched #(
      .S_INDEX (S_INDEX),
      .WIDTH   (WIDTH),
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .flush_req  (flush_req),
      .flush_done (flush_done),
      .arr_csb    (arr_csb),
      .arr_web    (arr_web),
      .arr_addr   (arr_addr),
      .arr_din    (arr_din),
      .arr_dout   (arr_dout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic we, input logic [3:0] a,
                          input logic d);
      req_valid[r]       = v;
      req_we[r]          = we;
      req_addr[r*4 +: 4] = a;
      req_wdata[r]       = d;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(req_ready), 0);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 0);
      chk({tag, "_rdata"}, 32'(resp_rdata), 0);
      chk({tag, "_done"}, 32'(flush_done), 0);
      chk({tag, "_csb"}, 32'(arr_csb), 1);
      chk({tag, "_web"}, 32'(arr_web), 1);
      chk({tag, "_addr"}, 32'(arr_addr), 0);
      chk({tag, "_din"}, 32'(arr_din), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      flush_req = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk_reset_outputs("rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Cycle 0: INIT disarm read, request present but not granted.
      set_req(0, 1'b1, 1'b0, 4'd5, 1'b0);
      #2;
      chk("init_csb", 32'(arr_csb), 0);
      chk("init_web", 32'(arr_web), 1);
      chk("init_addr", 32'(arr_addr), 0);
      chk("init_ready", 32'(req_ready), 0);
      // Cycle 1: first grant.
      next_cycle();
      #2;
      chk("g1_ready", 32'(req_ready), 32'b01);
      chk("g1_csb", 32'(arr_csb), 0);
      chk("g1_web", 32'(arr_web), 1);
      chk("g1_addr", 32'(arr_addr), 5);
      chk("g1_resp", 32'(resp_valid), 0);
      // Cycle 2: response.
      next_cycle();
      set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
      #2;
      chk("r1_valid", 32'(resp_valid), 32'b01);
      chk("r1_rdata", 32'(resp_rdata), 0);
      chk("r1_ready", 32'(req_ready), 0);
      chk("idle_csb", 32'(arr_csb), 1);

      // Write 1 to index 3 from req1, read back-to-back from req0.
      next_cycle();
      set_req(1, 1'b1, 1'b1, 4'd3, 1'b1);
      #2;
      chk("wr_ready", 32'(req_ready), 32'b10);
      chk("wr_web", 32'(arr_web), 0);
      chk("wr_addr", 32'(arr_addr), 3);
      chk("wr_din", 32'(arr_din), 1);
      next_cycle();
      set_req(1, 1'b0, 1'b0, 4'd0, 1'b0);
      set_req(0, 1'b1, 1'b0, 4'd3, 1'b0);
      #2;
      chk("wack_valid", 32'(resp_valid), 32'b10);
      chk("wack_rdata", 32'(resp_rdata), 0);
      chk("rd_ready", 32'(req_ready), 32'b01);
      next_cycle();
      set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
      set_req(1, 1'b1, 1'b0, 4'd3, 1'b0);
      #2;
      chk("raw_valid", 32'(resp_valid), 32'b01);
      chk("raw_rdata", 32'(resp_rdata), 1);
      chk("r1rd_ready", 32'(req_ready), 32'b10);

      // Both requesters hold reads from prio=0: grants alternate 0,1,0,1,0,1.
      next_cycle();
      set_req(0, 1'b1, 1'b0, 4'd3, 1'b0);
      set_req(1, 1'b1, 1'b0, 4'd0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         #2;
         chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
         if (k == 0) begin
            chk("rr_resp", 32'(resp_valid), 32'b10);
            chk("rr_rdata", 32'(resp_rdata), 1);
         end else begin
            chk("rr_resp", 32'(resp_valid), ((k - 1) % 2 == 0) ? 32'b01 : 32'b10);
            chk("rr_rdata", 32'(resp_rdata), ((k - 1) % 2 == 0) ? 1 : 0);
         end
         next_cycle();
      end
      set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
      set_req(1, 1'b0, 1'b0, 4'd0, 1'b0);
      #2;
      chk("rr_last_resp", 32'(resp_valid), 32'b10);
      chk("rr_last_rdata", 32'(resp_rdata), 0);
      chk("rr_last_ready", 32'(req_ready), 0);

      // Four writes of 1, then a read of 15 whose response coincides with flush_req.
      next_cycle();
      for (int j = 0; j < 4; j++) begin
         set_req(0, 1'b1, 1'b1, widx[j], 1'b1);
         #2;
         chk("fw_ready", 32'(req_ready), 32'b01);
         next_cycle();
      end
      set_req(0, 1'b1, 1'b0, 4'd15, 1'b0);
      #2;
      chk("rd15_ready", 32'(req_ready), 32'b01);
      next_cycle();
      set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
      set_req(1, 1'b1, 1'b0, 4'd0, 1'b0);
      flush_req = 1'b1;
      #2;
      chk("fl_resp_valid", 32'(resp_valid), 32'b01);
      chk("fl_rdata", 32'(resp_rdata), 1);
      chk("fl_ready", 32'(req_ready), 0);
      chk("fl_csb", 32'(arr_csb), 1);
      next_cycle();
      fdone_seen = 0;
      for (int i = 0; i < 16; i++) begin
         flush_req = (i == 3);  // repeated request inside FLUSH must be ignored
         #2;
         chk("fc_ready", 32'(req_ready), 0);
         chk("fc_csb", 32'(arr_csb), 0);
         chk("fc_web", 32'(arr_web), 0);
         chk("fc_addr", 32'(arr_addr), 32'(i));
         chk("fc_din", 32'(arr_din), 0);
         chk("fc_resp", 32'(resp_valid), 0);
         if (flush_done) fdone_seen++;
         next_cycle();
      end
      // FDONE: pulse done, grant-eligible, flush_req ignored here too.
      flush_req = 1'b1;
      #2;
      chk("fd_done", 32'(flush_done), 1);
      chk("fd_ready", 32'(req_ready), 32'b10);
      chk("fd_addr", 32'(arr_addr), 0);
      chk("fd_web", 32'(arr_web), 1);
      if (flush_done) fdone_seen++;
      next_cycle();
      flush_req = 1'b0;
      set_req(1, 1'b0, 1'b0, 4'd0, 1'b0);
      set_req(0, 1'b1, 1'b0, 4'd0, 1'b0);
      #2;
      chk("pf_resp", 32'(resp_valid), 32'b10);
      chk("pf_rdata", 32'(resp_rdata), 0);
      chk("pf_ready", 32'(req_ready), 32'b01);
      if (flush_done) fdone_seen++;
      next_cycle();
      for (int j = 1; j <= 16; j++) begin
         if (j < 16) set_req(0, 1'b1, 1'b0, 4'(j), 1'b0);
         else set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
         #2;
         chk("pf_rd_valid", 32'(resp_valid), 32'b01);
         chk("pf_rd_rdata", 32'(resp_rdata), 0);
         if (flush_done) fdone_seen++;
         next_cycle();
      end
      chk("one_flush_done", 32'(fdone_seen), 1);

      // Write 1 to index 9, start a flush, reset it at cnt=7.
      set_req(0, 1'b1, 1'b1, 4'd9, 1'b1);
      #2;
      next_cycle();
      set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
      flush_req = 1'b1;
      #2;
      chk("f2_ready", 32'(req_ready), 0);
      next_cycle();
      flush_req = 1'b0;
      for (int i = 0; i < 7; i++) next_cycle();
      set_req(0, 1'b1, 1'b0, 4'd9, 1'b0);
      #2;
      chk("mid_addr", 32'(arr_addr), 7);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      next_cycle();
      chk("midrst_hold_csb", 32'(arr_csb), 1);
      chk("midrst_hold_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      #2;
      chk("reinit_csb", 32'(arr_csb), 0);
      chk("reinit_web", 32'(arr_web), 1);
      chk("reinit_ready", 32'(req_ready), 0);
      fdone_seen = 0;
      if (flush_done) fdone_seen++;
      next_cycle();
      #2;
      chk("reidle_ready", 32'(req_ready), 32'b01);
      chk("reidle_addr", 32'(arr_addr), 9);
      next_cycle();
      set_req(0, 1'b0, 1'b0, 4'd0, 1'b0);
      #2;
      chk("idx9_valid", 32'(resp_valid), 32'b01);
      chk("idx9_rdata", 32'(resp_rdata), 1);
      for (int i = 0; i < 20; i++) begin
         if (flush_done) fdone_seen++;
         next_cycle();
      end
      chk("no_flush_done_after_rst", 32'(fdone_seen), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
